reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 9 +
 rtl/rob_ptr_inc.sv | 12 +
 rtl/reorder_buffer.sv | 114 +++++++++++
 tb/tb_reorder_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Core package shared by the ROB, register file and issue queue: tag sizing
// and the reserved "no tag" value.
package reorder_buffer_pkg;
  localparam int ROB_ENTRY_WIDTH = 5;
  localparam int DEPTH = (1 << ROB_ENTRY_WIDTH) - 1;
  localparam logic [ROB_ENTRY_WIDTH-1:0] NULL_TAG = '0;
  localparam int DATA_WIDTH = 32;
  localparam int REG_WIDTH = 5;
endpackage

// File: rtl/rob_ptr_inc.sv
// Wrapping pointer increment over tags 1..2^W-1; tag 0 is reserved and skipped.
module rob_ptr_inc #(
  parameter int W = 5
) (
  input  logic [W-1:0] ptr,
  output logic [W-1:0] next
);
  // the last valid tag is all ones, so wrap straight back to 1
  localparam logic [W-1:0] LAST = {W{1'b1}};

  assign next = (ptr == LAST) ? W'(1) : ptr + W'(1);
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: allocate at tail, fill from the CDB,
// retire one ready entry per cycle from head.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_Entry_WIDTH = ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alloc_valid,
  input  logic [REG_WIDTH-1:0]       alloc_drindex,
  output logic                       alloc_ready,
  output logic [ROB_Entry_WIDTH-1:0] alloc_roben,
  input  logic                       cdb_valid,
  input  logic [ROB_Entry_WIDTH-1:0] cdb_roben,
  input  logic [DATA_WIDTH-1:0]      cdb_data,
  input  logic [ROB_Entry_WIDTH-1:0] rd_roben1,
  input  logic [ROB_Entry_WIDTH-1:0] rd_roben2,
  output logic                       rd_ready1,
  output logic                       rd_ready2,
  output logic [DATA_WIDTH-1:0]      rd_data1,
  output logic [DATA_WIDTH-1:0]      rd_data2,
  output logic                       commit_wen,
  output logic [ROB_Entry_WIDTH-1:0] commit_roben,
  output logic [REG_WIDTH-1:0]       commit_drindex,
  output logic [DATA_WIDTH-1:0]      commit_data,
  output logic [ROB_Entry_WIDTH-1:0] count
);
  localparam int W = ROB_Entry_WIDTH;
  localparam int N = 1 << W;
  localparam logic [W-1:0] FULL = {W{1'b1}};
  localparam logic [W-1:0] NO_TAG = W'(NULL_TAG);

  // slot 0 exists only so any tag indexes safely; it is never made busy
  logic [N-1:0]           busy;
  logic [N-1:0]           ready;
  logic [REG_WIDTH-1:0]   drindex [N];
  logic [DATA_WIDTH-1:0]  data    [N];
  logic [W-1:0]           head, tail, head_next, tail_next;
  logic                   alloc_fire, commit_fire, cdb_hit;

  rob_ptr_inc #(.W(W)) u_head_inc (.ptr(head), .next(head_next));
  rob_ptr_inc #(.W(W)) u_tail_inc (.ptr(tail), .next(tail_next));

  assign alloc_ready = (count != FULL) && !flush;
  assign alloc_roben = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = busy[head] && ready[head];
  assign cdb_hit     = cdb_valid && (cdb_roben != NO_TAG) && busy[cdb_roben] && !ready[cdb_roben];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy           <= '0;
      ready          <= '0;
      head           <= W'(1);
      tail           <= W'(1);
      count          <= '0;
      commit_wen     <= 1'b0;
      commit_roben   <= '0;
      commit_drindex <= '0;
      commit_data    <= '0;
    end else if (flush) begin
      busy       <= '0;
      ready      <= '0;
      head       <= W'(1);
      tail       <= W'(1);
      count      <= '0;
      commit_wen <= 1'b0;
    end else begin
      if (cdb_hit) ready[cdb_roben] <= 1'b1;
      if (commit_fire) begin
        commit_wen     <= 1'b1;
        commit_roben   <= head;
        commit_drindex <= drindex[head];
        commit_data    <= data[head];
        busy[head]     <= 1'b0;
        ready[head]    <= 1'b0;
        head           <= head_next;
      end else begin
        commit_wen <= 1'b0;
      end
      // head==tail with a busy head means full, so alloc never collides with commit
      if (alloc_fire) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail_next;
      end
      if (alloc_fire && !commit_fire) count <= count + W'(1);
      else if (commit_fire && !alloc_fire) count <= count - W'(1);
    end
  end

  // payload needs no reset: busy/ready gate every use of it
  always_ff @(posedge clk) begin
    if (alloc_fire) drindex[tail] <= alloc_drindex;
    if (cdb_hit) data[cdb_roben] <= cdb_data;
  end

  function automatic logic [DATA_WIDTH:0] lookup(input logic [W-1:0] tag);
    logic [DATA_WIDTH:0] r;
    r = '0;
    if (tag != NO_TAG && busy[tag]) begin
      if (cdb_valid && cdb_roben == tag) r = {1'b1, cdb_data};
      else if (ready[tag]) r = {1'b1, data[tag]};
    end
    return r;
  endfunction

  always_comb begin
    {rd_ready1, rd_data1} = lookup(rd_roben1);
    {rd_ready2, rd_data2} = lookup(rd_roben2);
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, corner-case sequences and
// random traffic checked against a queue-based model of in-order retirement.
module tb_reorder_buffer;
  logic        clk = 1'b0, rst;
  logic        flush, alloc_valid, alloc_ready, cdb_valid;
  logic [4:0]  alloc_drindex, alloc_roben, cdb_roben, rd_roben1, rd_roben2;
  logic [31:0] cdb_data, rd_data1, rd_data2, commit_data;
  logic        rd_ready1, rd_ready2, commit_wen;
  logic [4:0]  commit_roben, commit_drindex, count;

  int n_pass = 0, n_total = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_drindex(alloc_drindex),
    .alloc_ready(alloc_ready), .alloc_roben(alloc_roben),
    .cdb_valid(cdb_valid), .cdb_roben(cdb_roben), .cdb_data(cdb_data),
    .rd_roben1(rd_roben1), .rd_roben2(rd_roben2),
    .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .commit_wen(commit_wen), .commit_roben(commit_roben),
    .commit_drindex(commit_drindex), .commit_data(commit_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush, alloc_valid;
    logic [4:0]  drindex;
    logic        cdb_valid;
    logic [4:0]  cdb_roben;
    logic [31:0] cdb_data;
    logic [4:0]  rd1, rd2;
  } in_t;

  typedef struct {
    in_t         in;
    logic [4:0]  e_roben;
    logic        e_wen;
    logic [4:0]  e_croben, e_cdr;
    logic [31:0] e_cdata;
    logic [4:0]  e_count;
  } vec_t;

  // model: in-order list of live entries, oldest first
  typedef struct { int tag; int dr; bit rdy; logic [31:0] data; } ent_t;
  ent_t        q[$];
  int          m_tail;
  int          m_wen, m_roben, m_dr;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic void model_reset();
    q.delete();
    m_tail = 1; m_wen = 0; m_roben = 0; m_dr = 0; m_data = '0;
  endfunction

  function automatic int find(input int tag);
    foreach (q[i]) if (q[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic in_t idle();
    in_t v;
    v.flush = 0; v.alloc_valid = 0; v.drindex = 0; v.cdb_valid = 0;
    v.cdb_roben = 0; v.cdb_data = 0; v.rd1 = 0; v.rd2 = 0;
    return v;
  endfunction

  function automatic logic [32:0] model_read(input int tag, input in_t v);
    int idx;
    if (tag == 0) return '0;
    idx = find(tag);
    if (idx < 0) return '0;
    if (v.cdb_valid && int'(v.cdb_roben) == tag) return {1'b1, v.cdb_data};
    if (q[idx].rdy) return {1'b1, q[idx].data};
    return '0;
  endfunction

  // Drive one cycle from a negedge, check the combinational outputs, clock,
  // advance the model and check the registered outputs.
  task automatic step(input in_t v);
    logic [32:0] r;
    bit alloc_ok, do_commit;
    int idx;
    ent_t e;
    flush = v.flush; alloc_valid = v.alloc_valid; alloc_drindex = v.drindex;
    cdb_valid = v.cdb_valid; cdb_roben = v.cdb_roben; cdb_data = v.cdb_data;
    rd_roben1 = v.rd1; rd_roben2 = v.rd2;
    #1;
    alloc_ok = v.alloc_valid && q.size() != 31 && !v.flush;
    chk("alloc_ready", {31'd0, alloc_ready}, {31'd0, (q.size() != 31) && !v.flush});
    chk("alloc_roben", 32'(alloc_roben), 32'(m_tail));
    r = model_read(v.rd1, v);
    chk("rd_ready1", {31'd0, rd_ready1}, {31'd0, r[32]});
    chk("rd_data1", rd_data1, r[31:0]);
    r = model_read(v.rd2, v);
    chk("rd_ready2", {31'd0, rd_ready2}, {31'd0, r[32]});
    chk("rd_data2", rd_data2, r[31:0]);
    @(posedge clk);
    if (v.flush) begin
      q.delete(); m_tail = 1; m_wen = 0;
    end else begin
      do_commit = q.size() > 0 && q[0].rdy;
      if (v.cdb_valid && v.cdb_roben != 0) begin
        idx = find(v.cdb_roben);
        if (idx >= 0 && !q[idx].rdy) begin q[idx].rdy = 1; q[idx].data = v.cdb_data; end
      end
      if (do_commit) begin
        m_wen = 1; m_roben = q[0].tag; m_dr = q[0].dr; m_data = q[0].data;
        void'(q.pop_front());
      end else m_wen = 0;
      if (alloc_ok) begin
        e.tag = m_tail; e.dr = v.drindex; e.rdy = 0; e.data = '0;
        q.push_back(e);
        m_tail = (m_tail == 31) ? 1 : m_tail + 1;
      end
    end
    #1;
    chk("commit_wen", {31'd0, commit_wen}, 32'(m_wen));
    chk("commit_roben", 32'(commit_roben), 32'(m_roben));
    chk("commit_drindex", 32'(commit_drindex), 32'(m_dr));
    chk("commit_data", commit_data, m_data);
    chk("count", 32'(count), 32'(q.size()));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    in_t v;
    v = idle();
    flush = 0; alloc_valid = 0; cdb_valid = 0;
    #2 rst = 1;
    #1;
    chk("rst_commit_wen", {31'd0, commit_wen}, 32'd0);
    chk("rst_commit_roben", 32'(commit_roben), 32'd0);
    chk("rst_commit_drindex", 32'(commit_drindex), 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alloc_roben", 32'(alloc_roben), 32'd1);
    #1 rst = 0;
    model_reset();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] dr, input logic cv,
                              input logic [4:0] ct, input logic [31:0] cd,
                              input logic [4:0] er, input logic ew, input logic [4:0] ecr,
                              input logic [4:0] ecd, input logic [31:0] edat, input logic [4:0] ec);
    vec_t t;
    t.in = idle();
    t.in.alloc_valid = av; t.in.drindex = dr; t.in.cdb_valid = cv;
    t.in.cdb_roben = ct; t.in.cdb_data = cd;
    t.e_roben = er; t.e_wen = ew; t.e_croben = ecr; t.e_cdr = ecd; t.e_cdata = edat; t.e_count = ec;
    return t;
  endfunction

  vec_t vecs[7];

  initial begin
    in_t v;
    model_reset();
    rst = 1;
    v = idle();
    flush = 0; alloc_valid = 0; alloc_drindex = 0; cdb_valid = 0; cdb_roben = 0;
    cdb_data = 0; rd_roben1 = 0; rd_roben2 = 0;
    #12;
    chk("reset_commit_wen", {31'd0, commit_wen}, 32'd0);
    chk("reset_commit_data", commit_data, 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_alloc_roben", 32'(alloc_roben), 32'd1);
    chk("reset_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    @(negedge clk);
    rst = 0;

    // alloc r3,r4; results arrive out of order; commits still in order
    vecs[0] = mk(1, 3, 0, 0, 0,        1, 0, 0, 0, 0,        1);
    vecs[1] = mk(1, 4, 0, 0, 0,        2, 0, 0, 0, 0,        2);
    vecs[2] = mk(0, 0, 1, 2, 32'hBB,   3, 0, 0, 0, 0,        2);
    vecs[3] = mk(0, 0, 1, 1, 32'hAA,   3, 0, 0, 0, 0,        2);
    vecs[4] = mk(0, 0, 0, 0, 0,        3, 1, 1, 3, 32'hAA,   1);
    vecs[5] = mk(0, 0, 0, 0, 0,        3, 1, 2, 4, 32'hBB,   0);
    vecs[6] = mk(0, 0, 0, 0, 0,        3, 0, 2, 4, 32'hBB,   0);
    for (int i = 0; i < 7; i++) begin
      chk("vec_alloc_roben", 32'(alloc_roben), 32'(vecs[i].e_roben));
      step(vecs[i].in);
      chk("vec_commit_wen", {31'd0, commit_wen}, {31'd0, vecs[i].e_wen});
      chk("vec_commit_roben", 32'(commit_roben), 32'(vecs[i].e_croben));
      chk("vec_commit_drindex", 32'(commit_drindex), 32'(vecs[i].e_cdr));
      chk("vec_commit_data", commit_data, vecs[i].e_cdata);
      chk("vec_count", 32'(count), 32'(vecs[i].e_count));
    end

    // fill to 31, refuse the 32nd, free one, wrap the tail
    pulse_reset();
    for (int i = 0; i < 31; i++) begin
      v = idle(); v.alloc_valid = 1; v.drindex = 5'(i); step(v);
    end
    chk("full_count", 32'(count), 32'd31);
    chk("full_alloc_ready", {31'd0, alloc_ready}, 32'd0);
    v = idle(); v.alloc_valid = 1; step(v);
    chk("refused_count", 32'(count), 32'd31);
    v = idle(); v.cdb_valid = 1; v.cdb_roben = 1; v.cdb_data = 32'h11; step(v);
    step(idle());
    chk("free_commit_roben", 32'(commit_roben), 32'd1);
    chk("free_count", 32'(count), 32'd30);
    chk("wrap_alloc_roben", 32'(alloc_roben), 32'd1);
    v = idle(); v.alloc_valid = 1; v.drindex = 5'd9; step(v);
    chk("refill_count", 32'(count), 32'd31);

    // full with a ready head: commit happens, simultaneous alloc refused
    v = idle(); v.cdb_valid = 1; v.cdb_roben = 2; v.cdb_data = 32'h22; step(v);
    v = idle(); v.alloc_valid = 1; step(v);
    chk("fullc_commit_wen", {31'd0, commit_wen}, 32'd1);
    chk("fullc_commit_roben", 32'(commit_roben), 32'd2);
    chk("fullc_count", 32'(count), 32'd30);

    // same-cycle CDB bypass on a read port; tag 0 reads nothing
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      v = idle(); v.alloc_valid = 1; v.drindex = 5'(i + 1); step(v);
    end
    cdb_valid = 1; cdb_roben = 5; cdb_data = 32'h1234; rd_roben1 = 5; rd_roben2 = 0;
    #1;
    chk("bypass_rd_ready1", {31'd0, rd_ready1}, 32'd1);
    chk("bypass_rd_data1", rd_data1, 32'h1234);
    chk("tag0_rd_ready2", {31'd0, rd_ready2}, 32'd0);
    chk("tag0_rd_data2", rd_data2, 32'd0);
    v = idle(); v.cdb_valid = 1; v.cdb_roben = 5; v.cdb_data = 32'h1234; v.rd1 = 5; step(v);

    // flush beats simultaneous alloc and CDB
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      v = idle(); v.alloc_valid = 1; v.drindex = 5'(i); step(v);
    end
    v = idle(); v.cdb_valid = 1; v.cdb_roben = 1; v.cdb_data = 32'h77; step(v);
    v = idle(); v.flush = 1; v.alloc_valid = 1; v.cdb_valid = 1; v.cdb_roben = 3; step(v);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_commit_wen", {31'd0, commit_wen}, 32'd0);
    chk("flush_alloc_roben", 32'(alloc_roben), 32'd1);

    // reset mid-stream; stale CDB afterwards is ignored
    v = idle(); v.alloc_valid = 1; v.drindex = 7; step(v);
    v = idle(); v.alloc_valid = 1; v.drindex = 8; step(v);
    v = idle(); v.cdb_valid = 1; v.cdb_roben = 1; v.cdb_data = 32'h55; step(v);
    step(idle());
    chk("pre_rst_commit_wen", {31'd0, commit_wen}, 32'd1);
    pulse_reset();
    v = idle(); v.cdb_valid = 1; v.cdb_roben = 2; v.cdb_data = 32'h99; step(v);
    step(idle());
    chk("stale_cdb_commit_wen", {31'd0, commit_wen}, 32'd0);
    chk("stale_cdb_count", 32'(count), 32'd0);
    chk("post_rst_alloc_roben", 32'(alloc_roben), 32'd1);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      v = idle();
      v.flush = ($urandom_range(0, 59) == 0);
      v.alloc_valid = ($urandom_range(0, 9) < 6);
      v.drindex = 5'($urandom);
      v.cdb_valid = ($urandom_range(0, 1) == 1);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) v.cdb_roben = 5'(q[$urandom_range(0, q.size() - 1)].tag);
      else v.cdb_roben = 5'($urandom_range(0, 31));
      v.cdb_data = $urandom;
      if (q.size() > 0 && $urandom_range(0, 2) != 0) v.rd1 = 5'(q[$urandom_range(0, q.size() - 1)].tag);
      else v.rd1 = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) v.rd1 = v.cdb_roben;
      v.rd2 = 5'($urandom_range(0, 31));
      step(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
